// File: rtl/commutate_nonoverlap.sv
`default_nettype none
// ============================================================================
//  Module      : commutate_nonoverlap
//  Description : BLDC six-step commutation with per-phase PWM application,
//                regen braking and non-overlap dead time on every gate pair.
//  Revision    : 1.0  initial release
// ============================================================================
module commutate_nonoverlap #(
  parameter int DEAD = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PWM_sig,
  input  logic PWM_synch,
  input  logic hallGrn,
  input  logic hallYlw,
  input  logic hallBlu,
  input  logic brake_n,
  output logic highGrn,
  output logic lowGrn,
  output logic highYlw,
  output logic lowYlw,
  output logic highBlu,
  output logic lowBlu,
  output logic hall_err
);

  typedef enum logic [0:0] {
    S_ACTIVE = 1'b0,
    S_DEAD   = 1'b1
  } dt_state_t;

  localparam logic [5:0] c_CNT_LAST = 6'(DEAD - 1);

  // Phase index used throughout: 0 = green, 1 = yellow, 2 = blue.
  logic [2:0] r_hall_s1;
  logic [2:0] r_hall_s2;
  logic       r_brk_s1;
  logic       r_brk_s2;
  logic [2:0] r_rot_state;
  logic       r_hall_err;
  logic       w_hall_bad;
  logic [2:0] w_fwd;
  logic [2:0] w_rev;
  logic [2:0] w_h_d;
  logic [2:0] w_l_d;

  // Two-flop synchronisers for the asynchronous halls and brake request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hall_s1 <= 3'b000;
      r_hall_s2 <= 3'b000;
      r_brk_s1  <= 1'b1;
      r_brk_s2  <= 1'b1;
    end else begin
      r_hall_s1 <= {hallGrn, hallYlw, hallBlu};
      r_hall_s2 <= r_hall_s1;
      r_brk_s1  <= brake_n;
      r_brk_s2  <= r_brk_s1;
    end
  end

  assign w_hall_bad = (r_hall_s2 == 3'b000) || (r_hall_s2 == 3'b111);

  // Hall state is only sampled at PWM period boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rot_state <= 3'b000;
      r_hall_err  <= 1'b0;
    end else if (PWM_synch) begin
      r_rot_state <= r_hall_s2;
      r_hall_err  <= w_hall_bad;
    end
  end

  // Commutation table: one-hot forward and reverse phases; the rest are Z.
  always_comb begin
    w_fwd = 3'b000;
    w_rev = 3'b000;
    case (r_rot_state)
      3'b101: begin w_fwd = 3'b001; w_rev = 3'b010; end
      3'b100: begin w_fwd = 3'b001; w_rev = 3'b100; end
      3'b110: begin w_fwd = 3'b010; w_rev = 3'b100; end
      3'b010: begin w_fwd = 3'b010; w_rev = 3'b001; end
      3'b011: begin w_fwd = 3'b100; w_rev = 3'b001; end
      3'b001: begin w_fwd = 3'b100; w_rev = 3'b010; end
      default: begin w_fwd = 3'b000; w_rev = 3'b000; end
    endcase
  end

  // Desired gate pair per phase; braking shorts every winding through the low side.
  always_comb begin
    w_h_d = 3'b000;
    w_l_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (!r_brk_s2) begin
        w_h_d[i] = 1'b0;
        w_l_d[i] = PWM_sig;
      end else if (w_fwd[i]) begin
        w_h_d[i] = PWM_sig;
        w_l_d[i] = ~PWM_sig;
      end else if (w_rev[i]) begin
        w_h_d[i] = ~PWM_sig;
        w_l_d[i] = PWM_sig;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    dt_state_t  r_state;
    dt_state_t  w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;
    logic [1:0] r_prev;
    logic       r_hi;
    logic       r_lo;
    logic       w_hi_nxt;
    logic       w_lo_nxt;
    logic       w_chg;

    assign w_chg = ({w_h_d[gi], w_l_d[gi]} != r_prev);

    // Dead-time state, counter, registered gates and last desired value.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= S_DEAD;
        r_cnt   <= 6'd0;
        r_prev  <= 2'b00;
        r_hi    <= 1'b0;
        r_lo    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_prev  <= {w_h_d[gi], w_l_d[gi]};
        r_hi    <= w_hi_nxt;
        r_lo    <= w_lo_nxt;
      end
    end

    // Any change of desired value forces both gates off and (re)starts the dead count.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hi_nxt    = 1'b0;
      w_lo_nxt    = 1'b0;
      case (r_state)
        S_ACTIVE: begin
          if (w_chg) begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_hi_nxt = w_h_d[gi];
            w_lo_nxt = w_l_d[gi];
          end
        end
        default: begin
          if (w_chg) begin
            w_cnt_nxt = 6'd0;
          end else if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_ACTIVE;
            w_hi_nxt    = w_h_d[gi];
            w_lo_nxt    = w_l_d[gi];
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      endcase
    end
  end

  assign highGrn  = g_phase[0].r_hi;
  assign lowGrn   = g_phase[0].r_lo;
  assign highYlw  = g_phase[1].r_hi;
  assign lowYlw   = g_phase[1].r_lo;
  assign highBlu  = g_phase[2].r_hi;
  assign lowBlu   = g_phase[2].r_lo;
  assign hall_err = r_hall_err;

endmodule
`default_nettype wire

// File: tb/tb_commutate_nonoverlap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commutate_nonoverlap
//  Description : Directed self-checking bench for commutate_nonoverlap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_commutate_nonoverlap;

  logic clk = 1'b0;
  logic rst_n, PWM_sig, PWM_synch, hallGrn, hallYlw, hallBlu, brake_n;
  logic highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, hall_err;
  int   checks   = 0;
  int   failures = 0;
  logic r_any_on;

  commutate_nonoverlap #(.DEAD(32)) dut (
    .clk(clk), .rst_n(rst_n), .PWM_sig(PWM_sig), .PWM_synch(PWM_synch),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu), .brake_n(brake_n),
    .highGrn(highGrn), .lowGrn(lowGrn), .highYlw(highYlw), .lowYlw(lowYlw),
    .highBlu(highBlu), .lowBlu(lowBlu), .hall_err(hall_err)
  );

  always #5 clk = ~clk;

  // Shoot-through monitor: high and low of one phase must never be on together.
  always @(negedge clk) begin
    checks++;
    assert (((highGrn & lowGrn) | (highYlw & lowYlw) | (highBlu & lowBlu)) === 1'b0)
      else begin
        failures++;
        $error("FAIL overlap: G=%b%b Y=%b%b B=%b%b required no pair 11",
               highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu);
      end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Gate vector order: {hG, lG, hY, lY, hB, lB}
  function automatic logic [7:0] gates();
    return {2'b00, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu};
  endfunction

  task automatic set_halls(input logic [2:0] h);
    {hallGrn, hallYlw, hallBlu} = h;
  endtask

  task automatic synch_pulse();
    PWM_synch = 1'b1;
    step(1);
    PWM_synch = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; PWM_sig = 1'b1; PWM_synch = 1'b0; brake_n = 1'b1;
    set_halls(3'b101);
    step(3);
    check("reset_gates", gates(), 8'h00);
    check("reset_err", {7'd0, hall_err}, 8'h00);

    // 1: latch 101 with PWM high -> G fwd high, Y rev low after dead time.
    rst_n = 1'b1;
    step(3);
    synch_pulse();
    step(32);
    check("t1_dead_last", gates(), 8'h00);
    step(1);
    check("t1_active", gates(), 8'b0010_0100);
    check("t1_err", {7'd0, hall_err}, 8'h00);

    // 2: PWM 1->0: highGrn off next edge, lowGrn on 33 cycles after the change.
    PWM_sig = 1'b0;
    step(1);
    check("t2_off", gates(), 8'h00);
    step(31);
    check("t2_still_dead", {7'd0, lowGrn}, 8'h00);
    step(1);
    check("t2_on", gates(), 8'b0001_1000);

    // 3: halls change without synch -> nothing; after synch Y goes Z, B rev.
    set_halls(3'b100);
    step(10);
    check("t3_no_synch", gates(), 8'b0001_1000);
    synch_pulse();
    step(1);
    check("t3_ylw_off", gates(), 8'b0001_0000);
    step(32);
    check("t3_blu_rev", gates(), 8'b0001_0010);

    // 4: illegal hall 111 -> hall_err, all gates off within one cycle.
    set_halls(3'b111);
    step(3);
    synch_pulse();
    check("t4_err", {7'd0, hall_err}, 8'h01);
    step(1);
    check("t4_gates", gates(), 8'h00);

    // 5: rot=110, brake with PWM high -> highs off, all lows on after dead time.
    PWM_sig = 1'b1;
    set_halls(3'b110);
    step(3);
    synch_pulse();
    check("t5_err_clr", {7'd0, hall_err}, 8'h00);
    brake_n = 1'b0;
    step(3);
    check("t5_highs", {5'd0, highGrn, highYlw, highBlu}, 8'h00);
    step(31);
    check("t5_grn_dead", {7'd0, lowGrn}, 8'h00);
    step(1);
    check("t5_lows", gates(), 8'b0001_0101);

    // 6: PWM pulses of width 10 keep restarting the dead count.
    r_any_on = 1'b0;
    for (int k = 0; k < 6; k++) begin
      PWM_sig = ~PWM_sig;
      for (int j = 0; j < 10; j++) begin
        step(1);
        if (gates() != 8'h00) r_any_on = 1'b1;
      end
    end
    check("t6_stay_off", {7'd0, r_any_on}, 8'h00);
    step(22);
    check("t6_dead_last", gates(), 8'h00);
    step(1);
    check("t6_release", gates(), 8'b0001_0101);

    // Reset mid-operation drops every gate on the reset edge.
    rst_n = 1'b0;
    step(1);
    check("reset_mid", gates(), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
